// File: rtl/control_sequencer.sv
// Hardwired T-state control unit for DataPath: fetches, decodes IR[31:27] and
// drives every DataPath control line as a Moore decode of (state, opcode, ConOut).
module control_sequencer (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        ConOut,
  input  logic        stop,
  output logic        HiIn, LoIn, ZIn, PCIn, MDRIn, MARIn, YIn, OPortIn, IRIn,
  output logic        HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut, IPortOut, COut,
  output logic        Gra, Grb, Grc, RIn, ROut, BAOut, Conin,
  output logic        memread, memwrite,
  output logic [4:0]  ALUCode,
  output logic        Run,
  output logic [3:0]  state_dbg
);
  localparam logic [4:0] ALU_ADD = 5'b00011;
  localparam logic [4:0] ALU_INC = 5'b11111;

  localparam logic [3:0] S_RESET = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3,
                         S_T3 = 4'd4, S_T4 = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7,
                         S_T7 = 4'd8, S_HALT = 4'd9;

  logic [3:0] state, state_nxt, last_state;
  logic [4:0] op, imm_code;
  logic       is_alu, is_imm, is_muldiv, is_ld, is_st, is_br;
  logic       is_jr, is_in, is_out, is_mflo, is_mfhi, is_halt;
  logic       ir_unused;

  assign op        = IR[31:27];
  assign ir_unused = ^IR[26:0];
  assign state_dbg = state;

  assign is_alu    = (op >= 5'b00011) && (op <= 5'b01010);
  assign is_imm    = (op >= 5'b01100) && (op <= 5'b01110);
  assign is_muldiv = (op == 5'b01111) || (op == 5'b10000);
  assign is_ld     = (op == 5'b00000);
  assign is_st     = (op == 5'b00010);
  assign is_br     = (op == 5'b10011);
  assign is_jr     = (op == 5'b10100);
  assign is_in     = (op == 5'b10110);
  assign is_out    = (op == 5'b10111);
  assign is_mflo   = (op == 5'b11000);
  assign is_mfhi   = (op == 5'b11001);
  assign is_halt   = (op == 5'b11011);

  // andi/ori reuse the and/or ALU codes; addi uses the plain adder.
  assign imm_code = (op == 5'b01100) ? ALU_ADD : {2'b00, op[2:0]};

  always_comb begin
    if (is_ld || is_st)            last_state = S_T7;
    else if (is_muldiv || is_br)   last_state = S_T6;
    else if (is_alu || is_imm)     last_state = S_T5;
    else                           last_state = S_T3;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_RESET: state_nxt = S_T0;
      S_T0:    state_nxt = S_T1;
      S_T1:    state_nxt = S_T2;
      S_T2:    state_nxt = S_T3;
      S_T3, S_T4, S_T5, S_T6, S_T7: begin
        // Instruction boundary: stop (or a halt opcode) diverts to HALT.
        if (state == last_state) state_nxt = (is_halt || stop) ? S_HALT : S_T0;
        else                     state_nxt = state + 4'd1;
      end
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_RESET;
    endcase
  end

  always_ff @(negedge clock or negedge clear) begin
    if (!clear) state <= S_RESET;
    else        state <= state_nxt;
  end

  always_comb begin
    {HiIn, LoIn, ZIn, PCIn, MDRIn, MARIn, YIn, OPortIn, IRIn} = '0;
    {HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut, IPortOut, COut} = '0;
    {Gra, Grb, Grc, RIn, ROut, BAOut, Conin} = '0;
    {memread, memwrite} = '0;
    ALUCode = '0;
    Run = (state != S_RESET) && (state != S_HALT);
    case (state)
      S_T0: begin PCOut = 1'b1; MARIn = 1'b1; ZIn = 1'b1; ALUCode = ALU_INC; end
      S_T1: begin ZLoOut = 1'b1; PCIn = 1'b1; memread = 1'b1; MDRIn = 1'b1; end
      S_T2: begin MDROut = 1'b1; IRIn = 1'b1; end
      S_T3: begin
        if (is_alu || is_imm)       begin Grb = 1'b1; ROut = 1'b1; YIn = 1'b1; end
        else if (is_muldiv)         begin Gra = 1'b1; ROut = 1'b1; YIn = 1'b1; end
        else if (is_ld || is_st)    begin Grb = 1'b1; BAOut = 1'b1; YIn = 1'b1; end
        else if (is_br)             begin Gra = 1'b1; ROut = 1'b1; Conin = 1'b1; end
        else if (is_jr)             begin Gra = 1'b1; ROut = 1'b1; PCIn = 1'b1; end
        else if (is_mfhi)           begin Gra = 1'b1; RIn = 1'b1; HiOut = 1'b1; end
        else if (is_mflo)           begin Gra = 1'b1; RIn = 1'b1; LoOut = 1'b1; end
        else if (is_in)             begin Gra = 1'b1; RIn = 1'b1; IPortOut = 1'b1; end
        else if (is_out)            begin Gra = 1'b1; ROut = 1'b1; OPortIn = 1'b1; end
      end
      S_T4: begin
        if (is_alu)                 begin Grc = 1'b1; ROut = 1'b1; ZIn = 1'b1; ALUCode = op; end
        else if (is_imm)            begin COut = 1'b1; ZIn = 1'b1; ALUCode = imm_code; end
        else if (is_muldiv)         begin Grb = 1'b1; ROut = 1'b1; ZIn = 1'b1; ALUCode = op; end
        else if (is_ld || is_st)    begin COut = 1'b1; ZIn = 1'b1; ALUCode = ALU_ADD; end
        else if (is_br)             begin PCOut = 1'b1; YIn = 1'b1; end
      end
      S_T5: begin
        if (is_alu || is_imm)       begin ZLoOut = 1'b1; Gra = 1'b1; RIn = 1'b1; end
        else if (is_muldiv)         begin ZLoOut = 1'b1; LoIn = 1'b1; end
        else if (is_ld || is_st)    begin ZLoOut = 1'b1; MARIn = 1'b1; end
        else if (is_br)             begin COut = 1'b1; ZIn = 1'b1; ALUCode = ALU_ADD; end
      end
      S_T6: begin
        if (is_muldiv)              begin ZHiOut = 1'b1; HiIn = 1'b1; end
        else if (is_ld)             begin memread = 1'b1; MDRIn = 1'b1; end
        else if (is_st)             begin Gra = 1'b1; ROut = 1'b1; MDRIn = 1'b1; end
        else if (is_br && ConOut)   begin ZLoOut = 1'b1; PCIn = 1'b1; end
      end
      S_T7: begin
        if (is_ld)                  begin MDROut = 1'b1; Gra = 1'b1; RIn = 1'b1; end
        else if (is_st)             memwrite = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_control_sequencer.sv
// Directed + randomized bench for control_sequencer: a per-instruction step table
// model predicts the full control word seen at each rising edge.
module tb_control_sequencer;
  logic        clock, clear, ConOut, stop;
  logic [31:0] IR;
  logic        HiIn, LoIn, ZIn, PCIn, MDRIn, MARIn, YIn, OPortIn, IRIn;
  logic        HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut, IPortOut, COut;
  logic        Gra, Grb, Grc, RIn, ROut, BAOut, Conin, memread, memwrite, Run;
  logic [4:0]  ALUCode;
  logic [3:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  control_sequencer dut (
    .clock(clock), .clear(clear), .IR(IR), .ConOut(ConOut), .stop(stop),
    .HiIn(HiIn), .LoIn(LoIn), .ZIn(ZIn), .PCIn(PCIn), .MDRIn(MDRIn), .MARIn(MARIn),
    .YIn(YIn), .OPortIn(OPortIn), .IRIn(IRIn),
    .HiOut(HiOut), .LoOut(LoOut), .ZHiOut(ZHiOut), .ZLoOut(ZLoOut), .PCOut(PCOut),
    .MDROut(MDROut), .IPortOut(IPortOut), .COut(COut),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .RIn(RIn), .ROut(ROut), .BAOut(BAOut), .Conin(Conin),
    .memread(memread), .memwrite(memwrite), .ALUCode(ALUCode), .Run(Run),
    .state_dbg(state_dbg)
  );

  initial clock = 1'b1;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Bit positions of the observed control word; ALUCode sits in [31:27].
  localparam int HI_IN = 0, LO_IN = 1, Z_IN = 2, PC_IN = 3, MDR_IN = 4, MAR_IN = 5,
                 Y_IN = 6, OPORT_IN = 7, IR_IN = 8, HI_OUT = 9, LO_OUT = 10,
                 ZHI_OUT = 11, ZLO_OUT = 12, PC_OUT = 13, MDR_OUT = 14, IPORT_OUT = 15,
                 C_OUT = 16, GRA = 17, GRB = 18, GRC = 19, R_IN = 20, R_OUT = 21,
                 BA_OUT = 22, CON_IN = 23, MEM_RD = 24, MEM_WR = 25, RUN = 26;

  localparam int K_ALU = 0, K_IMM = 1, K_MULDIV = 2, K_LD = 3, K_ST = 4, K_BR = 5,
                 K_JR = 6, K_MFHI = 7, K_MFLO = 8, K_IN = 9, K_OUT = 10, K_NOP = 11,
                 K_HALT = 12;

  logic [31:0] obs;
  assign obs = {ALUCode, Run, memwrite, memread, Conin, BAOut, ROut, RIn, Grc, Grb, Gra,
                COut, IPortOut, MDROut, PCOut, ZLoOut, ZHiOut, LoOut, HiOut,
                IRIn, OPortIn, YIn, MARIn, MDRIn, PCIn, ZIn, LoIn, HiIn};

  function automatic logic [31:0] b(input int i);
    return 32'd1 << i;
  endfunction

  function automatic logic [31:0] alu(input logic [4:0] code);
    return {code, 27'd0};
  endfunction

  function automatic int kind_of(input logic [4:0] op);
    int v;
    v = int'(op);
    if (v == 0)                 return K_LD;
    if (v == 2)                 return K_ST;
    if (v >= 3 && v <= 10)      return K_ALU;
    if (v >= 12 && v <= 14)     return K_IMM;
    if (v == 15 || v == 16)     return K_MULDIV;
    if (v == 19)                return K_BR;
    if (v == 20)                return K_JR;
    if (v == 22)                return K_IN;
    if (v == 23)                return K_OUT;
    if (v == 24)                return K_MFLO;
    if (v == 25)                return K_MFHI;
    if (v == 27)                return K_HALT;
    return K_NOP;
  endfunction

  function automatic int latency(input logic [4:0] op);
    case (kind_of(op))
      K_LD, K_ST:       return 8;
      K_MULDIV, K_BR:   return 7;
      K_ALU, K_IMM:     return 6;
      default:          return 4;
    endcase
  endfunction

  // Control word expected during clock t (0-based) of an instruction.
  function automatic logic [31:0] exp_word(input logic [4:0] op, input int t, input logic con);
    logic [31:0] w;
    logic [4:0]  ic;
    int k;
    k  = kind_of(op);
    ic = (op == 5'd12) ? 5'b00011 : (op == 5'd13) ? 5'b00101 : 5'b00110;
    w  = b(RUN);
    if (t == 0)      w |= b(PC_OUT) | b(MAR_IN) | b(Z_IN) | alu(5'b11111);
    else if (t == 1) w |= b(ZLO_OUT) | b(PC_IN) | b(MEM_RD) | b(MDR_IN);
    else if (t == 2) w |= b(MDR_OUT) | b(IR_IN);
    else begin
      case (k)
        K_ALU, K_IMM: begin
          if (t == 3) w |= b(GRB) | b(R_OUT) | b(Y_IN);
          if (t == 4 && k == K_ALU) w |= b(GRC) | b(R_OUT) | b(Z_IN) | alu(op);
          if (t == 4 && k == K_IMM) w |= b(C_OUT) | b(Z_IN) | alu(ic);
          if (t == 5) w |= b(ZLO_OUT) | b(GRA) | b(R_IN);
        end
        K_MULDIV: begin
          if (t == 3) w |= b(GRA) | b(R_OUT) | b(Y_IN);
          if (t == 4) w |= b(GRB) | b(R_OUT) | b(Z_IN) | alu(op);
          if (t == 5) w |= b(ZLO_OUT) | b(LO_IN);
          if (t == 6) w |= b(ZHI_OUT) | b(HI_IN);
        end
        K_LD, K_ST: begin
          if (t == 3) w |= b(GRB) | b(BA_OUT) | b(Y_IN);
          if (t == 4) w |= b(C_OUT) | b(Z_IN) | alu(5'b00011);
          if (t == 5) w |= b(ZLO_OUT) | b(MAR_IN);
          if (t == 6 && k == K_LD) w |= b(MEM_RD) | b(MDR_IN);
          if (t == 6 && k == K_ST) w |= b(GRA) | b(R_OUT) | b(MDR_IN);
          if (t == 7 && k == K_LD) w |= b(MDR_OUT) | b(GRA) | b(R_IN);
          if (t == 7 && k == K_ST) w |= b(MEM_WR);
        end
        K_BR: begin
          if (t == 3) w |= b(GRA) | b(R_OUT) | b(CON_IN);
          if (t == 4) w |= b(PC_OUT) | b(Y_IN);
          if (t == 5) w |= b(C_OUT) | b(Z_IN) | alu(5'b00011);
          if (t == 6 && con) w |= b(ZLO_OUT) | b(PC_IN);
        end
        K_JR:   w |= b(GRA) | b(R_OUT) | b(PC_IN);
        K_MFHI: w |= b(GRA) | b(R_IN) | b(HI_OUT);
        K_MFLO: w |= b(GRA) | b(R_IN) | b(LO_OUT);
        K_IN:   w |= b(GRA) | b(R_IN) | b(IPORT_OUT);
        K_OUT:  w |= b(GRA) | b(R_OUT) | b(OPORT_IN);
        default: ;
      endcase
    end
    return w;
  endfunction

  task automatic check(input string tag, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    checks++;
    assert (!(memread && memwrite)) else begin
      errors++;
      $error("FAIL %s_memexcl observed=%b%b expected=not_both", tag, memread, memwrite);
    end
  endtask

  // Entered just after the negedge that starts T0; leaves just after the
  // negedge that ends the instruction (or at the posedge where clear drops).
  task automatic run_instr(input logic [31:0] ir, input logic con, input int stop_at,
                           input int abort_at, input string tag);
    int n;
    IR = ir;
    ConOut = con;
    n = latency(ir[31:27]);
    for (int t = 0; t < n; t++) begin
      if (t == stop_at) stop = 1'b1;
      @(posedge clock);
      check($sformatf("%s_t%0d", tag, t), exp_word(ir[31:27], t, con));
      if (t == abort_at) begin
        #2 clear = 1'b0;
        stop = 1'b0;
        return;
      end
      @(negedge clock); #1;
    end
    stop = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    clear = 1'b0;
    #1 check({tag, "_async"}, 32'd0);
    repeat (2) begin
      @(posedge clock);
      check({tag, "_held"}, 32'd0);
    end
    clear = 1'b1;
    @(negedge clock); #1;
  endtask

  task automatic check_halted(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      check($sformatf("%s_%0d", tag, i), 32'd0);
    end
  endtask

  function automatic logic [31:0] rand_ir(input logic [4:0] op);
    logic [31:0] r;
    r = $urandom();
    r[31:27] = op;
    return r;
  endfunction

  initial begin
    logic [4:0] op;
    clear = 1'b0; IR = 32'd0; ConOut = 1'b0; stop = 1'b0;
    repeat (3) begin
      @(posedge clock);
      check("reset", 32'd0);
    end
    clear = 1'b1;
    @(negedge clock); #1;

    run_instr(32'h1A2B8000, 1'b0, -1, -1, "add");
    run_instr(rand_ir(5'b00000), 1'b0, -1, -1, "ld");
    run_instr(rand_ir(5'b00010), 1'b1, -1, -1, "st");
    run_instr(rand_ir(5'b10011), 1'b1, -1, -1, "br_taken");
    run_instr(rand_ir(5'b10011), 1'b0, -1, -1, "br_not");
    run_instr(rand_ir(5'b11001), 1'b0, -1, -1, "mfhi");

    for (int i = 0; i < 32; i++) begin
      op = 5'(i);
      if (op != 5'b11011)
        run_instr(rand_ir(op), 1'($urandom_range(0, 1)), -1, -1, $sformatf("op%0d", i));
    end
    for (int i = 0; i < 60; i++) begin
      op = 5'($urandom_range(0, 31));
      if (op == 5'b11011) op = 5'b11010;
      run_instr(rand_ir(op), 1'($urandom_range(0, 1)), -1, -1, $sformatf("rnd%0d", i));
    end

    run_instr(rand_ir(5'b00000), 1'b0, 5, -1, "ld_stop");
    check_halted(20, "stop_halt");
    do_reset("rst_after_stop");

    run_instr(rand_ir(5'b11011), 1'b1, -1, -1, "halt");
    check_halted(20, "halt_op");
    do_reset("rst_after_halt");

    run_instr(rand_ir(5'b00010), 1'b0, -1, 6, "st_abort");
    do_reset("rst_mid_st");
    run_instr(32'h1A2B8000, 1'b0, -1, -1, "add_after_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control unit that sits directly upstream of `DataPath`. It is a Moore-style T-state sequencer: it fetches the instruction, decodes IR[31:27], and drives every `DataPath` control input (register enables, bus-source selects, memory strobes, `ALUCode`), one step per clock. It replaces the hand-driven per-state stimulus currently used in the `DataPath` benches.

## Interface
- `ALU_ADD`, 5'b00011, ALUCode for address/offset addition.
- `ALU_INC`, 5'b11111, ALUCode for PC+1.
- `clock`  in  1  system clock; state advances on the falling edge.
- `clear`  in  1  asynchronous, active-low reset (0 = reset).
- `IR`  in  32  instruction register contents from `DataPath`; opcode = IR[31:27].
- `ConOut`  in  1  branch condition flag from `DataPath`.
- `stop`  in  1  request halt at the next instruction boundary.
- `HiIn, LoIn, ZIn, PCIn, MDRIn, MARIn, YIn, OPortIn, IRIn`  out  1 each  register load enables.
- `HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut, IPortOut, COut`  out  1 each  bus source selects.
- `Gra, Grb, Grc, RIn, ROut, BAOut, Conin`  out  1 each  register-file select/strobe, condition latch.
- `memread, memwrite`  out  1 each  memory strobes.
- `ALUCode`  out  5  ALU operation.
- `Run`  out  1  high while executing; low in RESET/HALT.

## Operation
- States: RESET, T0–T7, HALT. Outputs are a pure decode of (state, opcode, ConOut). Every unlisted output is 0, and `ALUCode` is 0.
- Fetch, common to all opcodes:
  - T0: PCOut MARIn ZIn, ALUCode=ALU_INC.
  - T1: ZLoOut PCIn memread MDRIn.
  - T2: MDROut IRIn.
- Opcode map:
  - ld 00000, st 00010.
  - add 00011, sub 00100, and 00101, or 00110, shr 00111, shl 01000, ror 01001, rol 01010.
  - addi 01100, andi 01101, ori 01110.
  - mul 01111, div 10000.
  - br 10011, jr 10100, in 10110, out 10111, mflo 11000, mfhi 11001, nop 11010, halt 11011.
  - All other opcodes behave as nop.
- R-type ALU ops (ALUCode = opcode):
  - T3: Grb ROut YIn.
  - T4: Grc ROut ZIn.
  - T5: ZLoOut Gra RIn.
- Immediate ops (ALUCode: addi=ALU_ADD, andi=00101, ori=00110):
  - T3: Grb ROut YIn.
  - T4: COut ZIn.
  - T5: ZLoOut Gra RIn.
- mul/div (ALUCode = opcode):
  - T3: Gra ROut YIn.
  - T4: Grb ROut ZIn.
  - T5: ZLoOut LoIn.
  - T6: ZHiOut HiIn.
- ld:
  - T3: Grb BAOut YIn.
  - T4: COut ZIn, ALU_ADD.
  - T5: ZLoOut MARIn.
  - T6: memread MDRIn.
  - T7: MDROut Gra RIn.
- st: T3–T5 as ld; T6: Gra ROut MDRIn; T7: memwrite.
- br:
  - T3: Gra ROut Conin.
  - T4: PCOut YIn.
  - T5: COut ZIn, ALU_ADD.
  - T6: ZLoOut PCIn only if ConOut=1; otherwise all outputs 0.
- Single-step opcodes, T3 only:
  - jr: Gra ROut PCIn.
  - mfhi: Gra RIn HiOut.
  - mflo: Gra RIn LoOut.
  - in: Gra RIn IPortOut.
  - out: Gra ROut OPortIn.
  - nop: all outputs 0.
- halt: T3 outputs all 0, then the FSM enters HALT.
- Each instruction returns to T0 after its last listed state.

## Timing
- `clear`=0 forces RESET asynchronously: all outputs 0, `Run`=0.
- First falling edge after `clear` rises: RESET→T0, `Run`=1.
- State register updates on `clock` negedge. Outputs are stable for a full period. `DataPath` captures on the intervening posedge.
- Instruction latency in clocks, fetch included:
  - 4: jr, mfhi, mflo, in, out, nop.
  - 6: ALU, immediate.
  - 7: mul/div, br.
  - 8: ld, st.
- IR is valid from T3 onward. Decode in T0–T2 ignores IR.
- br: ConOut is sampled combinationally in T6, after being latched at the T3 posedge.
- `stop` is sampled on the last-state→T0 transition. If 1, the FSM goes to HALT instead of T0, and the in-flight instruction completes.
- HALT is sticky; only `clear` exits it.
- `clear` asserted mid-instruction aborts immediately. No partial strobe survives: memwrite drops asynchronously.
- `memread` and `memwrite` are never both 1. At most one bus source select is 1 in any state.

## Test plan
- Reset: hold `clear`=0 for 3 clocks → all outputs 0, `Run`=0. Release → T0 outputs (PCOut, MARIn, ZIn, ALUCode=5'b11111) on the next falling edge.
- add (IR=32'h1A2B8000, i.e. opcode 00011): T3 Grb ROut YIn; T4 Grc ROut ZIn with ALUCode=00011; T5 ZLoOut Gra RIn; back at T0 after 6 clocks.
- ld (opcode 00000): T6 memread MDRIn; T7 MDROut Gra RIn; 8-clock period. st (opcode 00010): memwrite only in T7.
- br (opcode 10011): with ConOut=1, T6 asserts ZLoOut PCIn; with ConOut=0, T6 outputs all 0; both return to T0 after 7 clocks.
- mfhi (opcode 11001): T3 HiOut Gra RIn, then T0. halt (11011): `Run`=0 and outputs stay 0 for 20 clocks until `clear`.
- Asserting `stop` during an ld's T5 → the ld completes T7, then HALT. Pulsing `clear` low mid-T6 of st → memwrite never asserted, FSM in RESET.
